// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: latches operands on start, runs one shared
// full-add cell LSB first for WIDTH cycles, then presents {cout,sum} with a done pulse.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sr, a_sr_nx;
  logic [WIDTH-1:0] b_sr, b_sr_nx;
  logic [WIDTH-1:0] res_sr, res_sr_nx;
  logic [WIDTH-1:0] sum_nx;
  logic             carry, carry_nx;
  logic             cout_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             bit_s_c;

  // Next-state and datapath: IDLE and DONE both accept a start request
  always_comb begin
    state_nx  = state;
    a_sr_nx   = a_sr;
    b_sr_nx   = b_sr;
    res_sr_nx = res_sr;
    carry_nx  = carry;
    cnt_nx    = cnt;
    sum_nx    = sum;
    cout_nx   = cout;
    bit_s_c   = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          a_sr_nx  = a;
          b_sr_nx  = b;
          carry_nx = cin;
          cnt_nx   = '0;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      RUN: begin
        bit_s_c   = a_sr[0] ^ b_sr[0] ^ carry;
        carry_nx  = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
        // Result fills from the MSB end so the last bit lands at WIDTH-1
        res_sr_nx = (res_sr >> 1) | (WIDTH'(bit_s_c) << (WIDTH - 1));
        a_sr_nx   = a_sr >> 1;
        b_sr_nx   = b_sr >> 1;
        cnt_nx    = cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          state_nx = DONE;
          sum_nx   = res_sr_nx;
          cout_nx  = carry_nx;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and datapath registers; busy/done registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nx;
      a_sr   <= a_sr_nx;
      b_sr   <= b_sr_nx;
      res_sr <= res_sr_nx;
      carry  <= carry_nx;
      cnt    <= cnt_nx;
      sum    <= sum_nx;
      cout   <= cout_nx;
      busy   <= (state_nx == RUN);
      done   <= (state_nx == DONE);
    end
  end

endmodule
